// File: rtl/hex_digit_sequencer.sv
// hex_digit_sequencer
//   Multi-digit hex character generator for seven-segment displays.
//   A prescaler produces a periodic one-cycle step tick. On each tick the
//   NUM_DIGITS-nibble value register holds, counts up, counts down or
//   rotates its digits left, depending on mode. Each nibble is decoded into
//   a registered seven-segment pattern that trails value by one clock.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset (overrides load and enable)
//   enable      1 = prescaler runs; 0 = prescaler and value frozen
//   mode        00 hold, 01 count up, 10 count down, 11 rotate digits left
//   load        one-cycle strobe: value <= load_value, prescaler restarts
//   load_value  value captured on load
//   tick        one-cycle pulse at each prescaler terminal count
//   value       current value register
//   wrap        one-cycle pulse when count up/down wraps
//   seg         digit i at seg[7i+6:7i], bit order {g,f,e,d,c,b,a}
//
// Build option
//   HEX_BLANK_LEADING_EN: when defined, digits above digit 0 are blanked
//   while they and every higher digit are zero.

module hex_digit_sequencer #(
    parameter int unsigned                NUM_DIGITS     = 4,
    parameter int unsigned                PRESCALE_WIDTH = 28,
    parameter logic [PRESCALE_WIDTH-1:0]  PRESCALE_MAX   = 28'd49_999_999,
    parameter bit                         SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     load_value,
    output logic                        tick,
    output logic [4*NUM_DIGITS-1:0]     value,
    output logic                        wrap,
    output logic [7*NUM_DIGITS-1:0]     seg
);

    localparam int unsigned W       = 4 * NUM_DIGITS;
    localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    mode_e                     mode_s;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tick_q, tick_d;
    logic [W-1:0]              value_q, value_d;
    logic                      wrap_q, wrap_d;
    logic [7*NUM_DIGITS-1:0]   seg_q, seg_d;
    logic [3:0]                nib;
    logic [6:0]                code;
`ifdef HEX_BLANK_LEADING_EN
    logic                      lead_zero;
`endif

    assign mode_s = mode_e'(mode);

    // Active-high segment codes, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Prescaler, step and wrap. Load has priority over both the terminal
    // count and a pending step, so a step coinciding with load is dropped.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        value_d = value_q;
        wrap_d  = 1'b0;
        if (load) begin
            value_d = load_value;
            presc_d = '0;
        end else if (enable) begin
            if (presc_q == PRESCALE_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            if (tick_q) begin
                case (mode_s)
                    MODE_HOLD: value_d = value_q;
                    MODE_UP: begin
                        value_d = value_q + 1'b1;
                        wrap_d  = (value_q == '1);
                    end
                    MODE_DOWN: begin
                        value_d = value_q - 1'b1;
                        wrap_d  = (value_q == '0);
                    end
                    MODE_ROTATE: begin
                        // Shift form rather than a part-select so a single
                        // digit (W == 4) degenerates cleanly to hold.
                        value_d = (value_q << 4) | (value_q >> (W - 4));
                    end
                endcase
            end
        end
    end

    // Segment decode. Digits are walked from the most significant down so
    // lead_zero means "this digit and all higher digits are zero".
    always_comb begin
        seg_d = '0;
        nib   = '0;
        code  = '0;
`ifdef HEX_BLANK_LEADING_EN
        lead_zero = 1'b1;
`endif
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            nib  = value_q[4*(NUM_DIGITS-1-k) +: 4];
            code = SEG_ACTIVE_LOW ? ~hex7(nib) : hex7(nib);
`ifdef HEX_BLANK_LEADING_EN
            lead_zero = lead_zero && (nib == 4'h0);
            if (lead_zero && (k != NUM_DIGITS - 1)) begin
                code = SEG_OFF;
            end
`endif
            seg_d[7*(NUM_DIGITS-1-k) +: 7] = code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            value_q <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            value_q <= value_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
        end
    end

    assign tick  = tick_q;
    assign value = value_q;
    assign wrap  = wrap_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_hex_digit_sequencer.sv
module tb_hex_digit_sequencer;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_ROT  = 2'b11;

    localparam logic [6:0] HEX_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset, enable, load;
    logic [1:0]  mode;
    logic [15:0] load_value;
    logic        tick, wrap;
    logic [15:0] value;
    logic [27:0] seg;

    int n_cmp = 0;
    int n_bad = 0;

    hex_digit_sequencer #(
        .NUM_DIGITS     (4),
        .PRESCALE_WIDTH (28),
        .PRESCALE_MAX   (28'd3),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .tick       (tick),
        .value      (value),
        .wrap       (wrap),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic        wrap;
    } exp_t;

    typedef struct {
        logic [15:0] ld;
        logic [1:0]  mode;
        int          steps;
        logic [15:0] exp_val;
        int          exp_wraps;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Expected display for a 4-digit value, active-low segments.
    function automatic logic [27:0] exp_seg(input logic [15:0] v);
        logic [27:0] r;
        logic [6:0]  p;
        logic [3:0]  n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            n = v[4*i +: 4];
            p = HEX_TBL[n];
`ifdef HEX_BLANK_LEADING_EN
            if (i > 0 && (v >> (4*i)) == 16'h0000) p = 7'h00;
`endif
            r[7*i +: 7] = ~p;
        end
        return r;
    endfunction

    function automatic exp_t model_step(input logic [15:0] v, input logic [1:0] m);
        exp_t e;
        logic [16:0] s;
        e.val  = v;
        e.wrap = 1'b0;
        case (m)
            M_UP: begin
                s = {1'b0, v} + 17'd1;
                e.val  = s[15:0];
                e.wrap = s[16];
            end
            M_DOWN: begin
                e.val  = v - 16'd1;
                e.wrap = (v == 16'h0000);
            end
            M_ROT: e.val = {v[11:0], v[15:12]};
            default: e.val = v;
        endcase
        return e;
    endfunction

    // Scoreboard monitor: every load or enabled tick seen at one falling
    // edge must show up in value/wrap at the next, and in seg one later.
    bit          mon_en = 1'b0;
    bit          ev_prev = 1'b0;
    bit          seg_pend = 1'b0;
    logic [27:0] seg_exp;
    int          wrap_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (seg_pend) begin
                chk("sb_seg", {4'h0, seg}, {4'h0, seg_exp});
                seg_pend = 1'b0;
            end
            if (ev_prev) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_step", {16'h0, value}, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_value", {16'h0, value}, {16'h0, e.val});
                    chk("sb_wrap", {31'h0, wrap}, {31'h0, e.wrap});
                    seg_exp  = exp_seg(e.val);
                    seg_pend = 1'b1;
                end
            end
            if (wrap) wrap_cnt++;
            ev_prev = load || (tick && enable);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic [15:0] v;
        int budget;

        vecs[0] = '{16'hFFFF, M_UP,   1, 16'h0000, 1};
        vecs[1] = '{16'h0000, M_DOWN, 1, 16'hFFFF, 1};
        vecs[2] = '{16'h1234, M_ROT,  4, 16'h1234, 0};
        vecs[3] = '{16'h00A0, M_HOLD, 1, 16'h00A0, 0};
        vecs[4] = '{16'h0000, M_HOLD, 1, 16'h0000, 0};
        vecs[5] = '{16'hFFFE, M_UP,   3, 16'h0001, 1};
        vecs[6] = '{16'h0001, M_DOWN, 2, 16'hFFFF, 1};
        vecs[7] = '{16'h0040, M_ROT,  1, 16'h0400, 0};
        vecs[8] = '{16'h00A0, M_UP,   3, 16'h00A3, 0};
        vecs[9] = '{16'h8000, M_DOWN, 1, 16'h7FFF, 0};

        reset = 1'b1; enable = 1'b0; mode = M_HOLD; load = 1'b0; load_value = '0;

        // Reset state and first tick after release.
        repeat (3) cyc();
        chk("rst_value", {16'h0, value}, 32'h0);
        chk("rst_tick", {31'h0, tick}, 32'h0);
        chk("rst_wrap", {31'h0, wrap}, 32'h0);
        chk("rst_seg", {4'h0, seg}, 32'h0FFF_FFFF);
        reset = 1'b0; enable = 1'b1; mode = M_UP;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chk("first_tick", {31'h0, tick}, (c == 4) ? 32'h1 : 32'h0);
        end
        cyc();
        chk("first_step", {16'h0, value}, 32'h0001);
        cyc();
        chk("first_seg0", {25'h0, seg[6:0]}, 32'h79);
        chk("first_seg", {4'h0, seg}, {4'h0, exp_seg(16'h0001)});

        // Reset beats a coincident load.
        reset = 1'b1; load = 1'b1; load_value = 16'h1234;
        cyc();
        chk("rst_over_load", {16'h0, value}, 32'h0);
        reset = 1'b0; load = 1'b0;

        // Enable freeze, resume, and load on the terminal-count cycle.
        load = 1'b1; load_value = 16'h5555; mode = M_UP; enable = 1'b1;
        cyc();
        load = 1'b0;
        cyc(); cyc();
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("frz_tick", {31'h0, tick}, 32'h0);
            chk("frz_value", {16'h0, value}, 32'h5555);
        end
        enable = 1'b1;
        cyc();
        chk("resume_tick_early", {31'h0, tick}, 32'h0);
        cyc();
        chk("resume_tick", {31'h0, tick}, 32'h1);
        cyc();
        chk("resume_step", {16'h0, value}, 32'h5556);
        cyc();
        cyc();
        chk("pre_tc_tick", {31'h0, tick}, 32'h0);
        load = 1'b1; load_value = 16'hABCD;
        cyc();
        load = 1'b0;
        chk("tc_load_value", {16'h0, value}, 32'hABCD);
        chk("tc_load_tick", {31'h0, tick}, 32'h0);
        chk("tc_load_wrap", {31'h0, wrap}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("restart_tick", {31'h0, tick}, 32'h0);
            chk("restart_value", {16'h0, value}, 32'hABCD);
        end
        cyc();
        chk("restart_tick_due", {31'h0, tick}, 32'h1);
        cyc();
        chk("restart_step", {16'h0, value}, 32'hABCE);

        // Table-driven vectors through the scoreboard.
        enable = 1'b0; mode = M_HOLD;
        cyc(); cyc();
        ev_prev  = 1'b0;
        seg_pend = 1'b0;
        mon_en   = 1'b1;
        foreach (vecs[i]) begin
            wrap_cnt = 0;
            load = 1'b1; load_value = vecs[i].ld; mode = vecs[i].mode; enable = 1'b1;
            e.val = vecs[i].ld; e.wrap = 1'b0;
            sbq.push_back(e);
            v = vecs[i].ld;
            for (int s = 0; s < vecs[i].steps; s++) begin
                e = model_step(v, vecs[i].mode);
                sbq.push_back(e);
                v = e.val;
            end
            cyc();
            load = 1'b0;
            budget = 4 * vecs[i].steps + 10;
            for (int c = 0; c < budget && sbq.size() != 0; c++) begin
                @(posedge clk);
            end
            #1;
            if (sbq.size() != 0) begin
                chk("sb_timeout", sbq.size(), 32'h0);
                sbq.delete();
            end
            enable = 1'b0;
            cyc(); cyc(); cyc();
            chk("vec_final_value", {16'h0, value}, {16'h0, vecs[i].exp_val});
            chk("vec_wrap_count", wrap_cnt, vecs[i].exp_wraps);
        end
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
